// File: rtl/bip_uart_pkg.sv
// Shared types and helpers for the BIP result-reporting UART.
// Frame FSM encoding, line levels and word-to-byte sizing.
package bip_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_st_e;

  localparam logic UART_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  function automatic int nb_bytes(input int nb_data);
    return (nb_data + 7) / 8;
  endfunction

endpackage

// File: rtl/bip_uart_byte_if.sv
// Byte handshake between the report sequencer and the frame serialiser.
// frame_end marks the last cycle of a frame's final stop bit.
interface bip_uart_byte_if;
  logic       valid;
  logic       ready;
  logic       frame_end;
  logic [7:0] data;

  modport src (
    output valid,
    output data,
    input  ready,
    input  frame_end
  );

  modport snk (
    input  valid,
    input  data,
    output ready,
    output frame_end
  );
endinterface

// File: rtl/bip_uart_tx_byte.sv
// Single-frame UART serialiser: start, 8 data bits LSB first,
// optional parity and 1-2 stop bits, each CLKS_PER_BIT cycles.
module bip_uart_tx_byte
  import bip_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int N_STOP       = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  bip_uart_byte_if.snk byte_if,
  output logic         o_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(N_STOP - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  uart_st_e      st_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic          tx_q;
  logic          baud_end;
  logic          frame_end;
  logic          ready;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign frame_end = (st_q == ST_STOP) && baud_end
                   && (stop_q == STOP_LAST);
  assign ready     = (st_q == ST_IDLE) || frame_end;

  assign byte_if.frame_end = frame_end;
  assign byte_if.ready     = ready;
  assign o_tx              = tx_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= ST_IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      stop_q <= 1'b0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      tx_q   <= UART_IDLE;
    end else if (byte_if.valid && ready) begin
      // Accepting on the last stop cycle keeps frames back-to-back.
      st_q   <= ST_START;
      tx_q   <= START_BIT;
      sh_q   <= byte_if.data;
      par_q  <= (^byte_if.data) ^ PAR_INV;
      baud_q <= '0;
      bit_q  <= '0;
      stop_q <= 1'b0;
    end else if (st_q != ST_IDLE) begin
      baud_q <= baud_end ? '0 : baud_q + CW'(1);
      if (baud_end) begin
        unique case (st_q)
          ST_START: begin
            st_q <= ST_DATA;
            tx_q <= sh_q[0];
          end
          ST_DATA: begin
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                st_q <= ST_PARITY;
                tx_q <= par_q;
              end else begin
                st_q <= ST_STOP;
                tx_q <= UART_IDLE;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end
          ST_PARITY: begin
            st_q <= ST_STOP;
            tx_q <= UART_IDLE;
          end
          ST_STOP: begin
            if (stop_q == STOP_LAST) begin
              st_q   <= ST_IDLE;
              stop_q <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/bip_uart_reporter.sv
// BIP report transmitter: snapshots N_WORDS words on i_start and
// streams them as UART frames, word 0 first, LSB byte first.
module bip_uart_reporter
  import bip_uart_pkg::*;
#(
  parameter int NB_DATA      = 16,
  parameter int N_WORDS      = 3,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int N_STOP       = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [N_WORDS*NB_DATA-1:0] i_words,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_tx
);

  localparam int NB_BYTES = nb_bytes(NB_DATA);
  localparam int NB_EXT   = NB_BYTES * 8;
  localparam int WW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int BW = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(N_WORDS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB_BYTES - 1);

  logic [N_WORDS*NB_DATA-1:0] snap_q;
  logic [N_WORDS*NB_DATA-1:0] src;
  logic [NB_EXT-1:0]          word_ext;
  logic [WW-1:0]              widx_q;
  logic [BW-1:0]              bidx_q;
  logic                       busy_q;
  logic                       pend_q;
  logic                       done_q;
  logic                       last_byte;
  logic                       hs;

  bip_uart_byte_if u_bif ();

  // The first byte goes out from i_words directly, on the accept edge.
  assign src         = busy_q ? snap_q : i_words;
  assign word_ext    = NB_EXT'(src[widx_q*NB_DATA +: NB_DATA]);
  assign u_bif.data  = word_ext[bidx_q*8 +: 8];
  assign u_bif.valid = busy_q ? pend_q : i_start;
  assign hs          = u_bif.valid && u_bif.ready;
  assign last_byte   = (widx_q == W_LAST) && (bidx_q == B_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snap_q <= '0;
      widx_q <= '0;
      bidx_q <= '0;
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q && i_start) begin
        snap_q <= i_words;
        busy_q <= 1'b1;
      end
      if (hs) begin
        pend_q <= !last_byte;
        if (bidx_q == B_LAST) begin
          bidx_q <= '0;
          widx_q <= (widx_q == W_LAST) ? '0 : widx_q + WW'(1);
        end else begin
          bidx_q <= bidx_q + BW'(1);
        end
      end
      if (busy_q && u_bif.frame_end && !pend_q) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  bip_uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY_EN    (PARITY_EN),
    .PARITY_ODD   (PARITY_ODD),
    .N_STOP       (N_STOP)
  ) u_tx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .byte_if (u_bif),
    .o_tx    (o_tx)
  );

  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_bip_uart_reporter.sv
// Bench for bip_uart_reporter: four parameter sets, each with a
// per-cycle line model, a UART decoder and literal expectations.
module tb_bip_uart_reporter;

  logic clk = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fin  = 0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int NB   = (g == 3) ? 11 : 16;
    localparam int NW   = (g == 0) ? 3 : 1;
    localparam int CPB  = (g == 0) ? 16 : (g == 1) ? 4 : (g == 2) ? 5 : 3;
    localparam int PEN  = (g == 0) ? 0 : 1;
    localparam int PODD = (g >= 2) ? 1 : 0;
    localparam int NSTP = (g == 1 || g == 3) ? 2 : 1;
    localparam int NBB  = (NB + 7) / 8;
    localparam int BUSY_LEN = (g == 0) ? 960 : (g == 1) ? 96
                            : (g == 2) ? 110 : 72;
    localparam int NFR  = (g == 0) ? 6 : 2;
    localparam int INJ  = BUSY_LEN * 5 / 16;
    localparam logic [47:0] DIR48 = (g == 0) ? 48'hFFFF_0001_A55A
                                  : (g == 3) ? 48'h7FF : 48'h005A;
    localparam logic [47:0] EXP_RX = (g == 0) ? 48'hFFFF_0001_A55A
                                   : (g == 3) ? 48'h07FF : 48'h005A;
    localparam logic [1:0] EXP_PAR = (g == 2) ? 2'b11
                                   : (g == 3) ? 2'b01 : 2'b00;

    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [NW*NB-1:0] words = '0;
    logic             tx, busy, done;

    bip_uart_reporter #(
      .NB_DATA(NB), .N_WORDS(NW), .CLKS_PER_BIT(CPB),
      .PARITY_EN(PEN), .PARITY_ODD(PODD), .N_STOP(NSTP)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_words(words), .o_busy(busy), .o_done(done), .o_tx(tx)
    );

    // Model: expected line level for each upcoming busy cycle.
    bit    mq [$];
    bit    mbusy = 1'b0;
    bit    etx, ebusy, edone;
    string mnm;

    initial begin
      mnm = $sformatf("cfg%0d tx/busy/done", g);
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          mq.delete();
          mbusy = 1'b0;
          etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
        end else begin
          if (!mbusy && start) begin
            for (int w = 0; w < NW; w++) begin
              logic [63:0] wv;
              wv = '0;
              wv[NB-1:0] = words[w*NB +: NB];
              for (int b = 0; b < NBB; b++) begin
                logic [7:0] by;
                bit fb [$];
                by = wv[b*8 +: 8];
                fb = {};
                fb.push_back(1'b0);
                for (int i = 0; i < 8; i++) fb.push_back(by[i]);
                if (PEN != 0) fb.push_back((^by) ^ (PODD != 0));
                for (int s = 0; s < NSTP; s++) fb.push_back(1'b1);
                foreach (fb[k])
                  for (int c = 0; c < CPB; c++) mq.push_back(fb[k]);
              end
            end
          end
          if (mq.size() > 0) begin
            etx = mq.pop_front(); ebusy = 1'b1; edone = 1'b0;
          end else begin
            etx = 1'b1; ebusy = 1'b0; edone = mbusy;
          end
          mbusy = ebusy;
        end
        #1;
        chk(mnm, {tx, busy, done}, {etx, ebusy, edone});
      end
    end

    // Mid-bit sampling decoder on the line.
    logic [7:0] rxq [$];
    bit         rxpar [$];
    bit         dact = 1'b0;
    logic       dprev = 1'b1;
    int         dt;
    logic [7:0] dsh;
    logic       dpar;

    always @(negedge clk) begin
      if (!rst_n) begin
        dact = 1'b0;
        dprev = 1'b1;
      end else if (!dact) begin
        if (dprev && !tx) begin
          dact = 1'b1;
          dt = 0;
        end
        dprev = tx;
      end else begin
        dt++;
        if (dt % CPB == CPB / 2) begin
          int bi;
          bi = dt / CPB;
          if (bi >= 1 && bi <= 8) dsh[bi-1] = tx;
          else if (bi == 9 && PEN != 0) dpar = tx;
          if (bi == 9 + PEN) begin
            rxq.push_back(dsh);
            if (PEN != 0) rxpar.push_back(dpar);
            dact = 1'b0;
            dprev = tx;
          end
        end
      end
    end

    task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < BUSY_LEN + 20 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk(nm, seen, 1);
    endtask

    initial begin
      int          nb, nd;
      bit          seen;
      logic [63:0] r64;
      logic [47:0] rxp;
      logic [1:0]  pp;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("cfg%0d reset state", g), {tx, busy, done}, 3'b100);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed report with an ignored start in the middle.
      rxq.delete(); rxpar.delete();
      words = DIR48[NW*NB-1:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nb = 0; nd = 0; seen = 1'b0;
      for (int i = 0; i < BUSY_LEN + 20 && !seen; i++) begin
        if (busy) nb++;
        if (done) begin nd++; seen = 1'b1; end
        if (i == INJ) begin start = 1'b1; words = ~words; end
        if (i == INJ + 1) start = 1'b0;
        @(negedge clk);
      end
      repeat (4) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk($sformatf("cfg%0d busy cycles", g), nb, BUSY_LEN);
      chk($sformatf("cfg%0d done pulses", g), nd, 1);
      chk($sformatf("cfg%0d frame count", g), rxq.size(), NFR);
      rxp = '0;
      foreach (rxq[k]) if (k < 6) rxp[k*8 +: 8] = rxq[k];
      chk($sformatf("cfg%0d rx bytes", g), rxp, EXP_RX);
      pp = '0;
      foreach (rxpar[k]) if (k < 2) pp[k] = rxpar[k];
      chk($sformatf("cfg%0d parity bits", g), pp, EXP_PAR);

      // Back-to-back reports with start held through o_done.
      r64 = {$urandom, $urandom};
      words = r64[NW*NB-1:0];
      start = 1'b1;
      @(negedge clk);
      wait_done($sformatf("cfg%0d b2b first done", g));
      chk($sformatf("cfg%0d b2b gap busy", g), busy, 0);
      r64 = {$urandom, $urandom};
      words = r64[NW*NB-1:0];
      @(negedge clk);
      chk($sformatf("cfg%0d b2b restart tx/busy", g), {tx, busy}, 2'b01);
      start = 1'b0;
      wait_done($sformatf("cfg%0d b2b second done", g));

      // Asynchronous reset in the middle of data bit 1 (a zero bit).
      @(negedge clk);
      words = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2 * CPB + CPB / 2) @(negedge clk);
      chk($sformatf("cfg%0d pre-reset tx/busy", g), {tx, busy}, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("cfg%0d async reset", g), {tx, busy, done}, 3'b100);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rxq.delete(); rxpar.delete();
      r64 = {$urandom, $urandom};
      words = r64[NW*NB-1:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done($sformatf("cfg%0d post-reset done", g));
      repeat (4) @(negedge clk);
      chk($sformatf("cfg%0d post-reset frames", g), rxq.size(), NFR);

      // Random reports, start held a random number of cycles.
      for (int n = 0; n < 3; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        r64 = {$urandom, $urandom};
        words = r64[NW*NB-1:0];
        start = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        start = 1'b0;
        wait_done($sformatf("cfg%0d random done %0d", g, n));
      end
      repeat (3) @(negedge clk);
      n_fin++;
    end
  end

  initial begin
    for (int i = 0; i < 30000 && n_fin < 4; i++) @(posedge clk);
    if (n_fin < 4) begin
      n_chk++;
      $display("FAIL timeout: got %0d configs finished expected 4", n_fin);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
